yutorina_bus_slave_if: RTL and testbench

- Responder-side bus interface. It sits between the shared system bus (arbiter, address decoder, read-data mux) and one slave device with a synchronous memory-style port (SPM-like RAM, ROM, or a peripheral register bank).
- Samples a one-cycle access strobe, drives the device port, and inserts configurable wait states.
- Returns `bus_rdy_` plus read data to the bus master that owns the grant.

---
 rtl/yutorina_bus_slave_if_pkg.sv | 32 +++
 rtl/yutorina_bus_slave_if.sv | 106 ++++++++++
 tb/tb_yutorina_bus_slave_if.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/yutorina_bus_slave_if_pkg.sv
// Shared bus definitions for the slave interface: word widths, the active-low
// enable and read/write codes, and the slave FSM state and wait-counter types.
package yutorina_bus_slave_if_pkg;

    localparam int WORD_ADDR_W = 30;
    localparam int WORD_DATA_W = 32;

    typedef logic [WORD_ADDR_W-1:0] word_addr_t;
    typedef logic [WORD_DATA_W-1:0] word_data_t;

    localparam logic       ENABLE_  = 1'b0;
    localparam logic       DISABLE_ = 1'b1;
    localparam logic       READ     = 1'b1;
    localparam logic       WRITE    = 1'b0;
    localparam word_data_t ZERO     = '0;

    typedef enum logic [2:0] {
        BUS_SLV_STATE_IDLE    = 3'd0,
        BUS_SLV_STATE_ACCESS  = 3'd1,
        BUS_SLV_STATE_CAPTURE = 3'd2,
        BUS_SLV_STATE_WAIT    = 3'd3,
        BUS_SLV_STATE_READY   = 3'd4
    } bus_slv_state_e;

    typedef logic [3:0] bus_slv_wait_t;

    // Counter preload for the WAIT state; the WAIT state itself supplies one cycle.
    function automatic bus_slv_wait_t wait_preload(input int wait_cycles);
        return (wait_cycles > 0) ? bus_slv_wait_t'(wait_cycles - 1) : '0;
    endfunction

endpackage

// File: rtl/yutorina_bus_slave_if.sv
// Responder-side bus interface: turns a one-cycle bus strobe into a device access,
// inserts WAIT_CYCLES wait states and returns a registered one-cycle ready pulse.
module yutorina_bus_slave_if
    import yutorina_bus_slave_if_pkg::*;
#(
    parameter int DEV_ADDR_W  = 12,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bus_cs_,
    input  logic                  bus_as_,
    input  logic                  bus_rw,
    input  word_addr_t            bus_addr,
    input  word_data_t            bus_w_data,
    output logic                  bus_rdy_,
    output word_data_t            bus_r_data,
    output logic                  dev_as_,
    output logic                  dev_rw,
    output logic [DEV_ADDR_W-1:0] dev_addr,
    output word_data_t            dev_w_data,
    input  word_data_t            dev_r_data
);

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("WAIT_CYCLES must be in 0..15");
    end

    localparam bus_slv_wait_t WAIT_INIT = wait_preload(WAIT_CYCLES);

    bus_slv_state_e state;
    bus_slv_wait_t  wait_cnt;
    word_data_t     rd_buf;

    // Upper address bits select this slave in the decoder and are not needed here.
    logic unused_addr;
    assign unused_addr = ^bus_addr[WORD_ADDR_W-1:DEV_ADDR_W];

    // NOTE: every register here updates with <= so all state moves on the same edge
    // using pre-edge values; a blocking = would let later statements see new values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= BUS_SLV_STATE_IDLE;
            wait_cnt   <= '0;
            rd_buf     <= ZERO;
            bus_rdy_   <= DISABLE_;
            bus_r_data <= ZERO;
            dev_as_    <= DISABLE_;
            dev_rw     <= READ;
            dev_addr   <= '0;
            dev_w_data <= ZERO;
        end else begin
            case (state)
                BUS_SLV_STATE_IDLE: begin
                    if (bus_cs_ == ENABLE_ && bus_as_ == ENABLE_) begin
                        state      <= BUS_SLV_STATE_ACCESS;
                        dev_addr   <= bus_addr[DEV_ADDR_W-1:0];
                        dev_rw     <= bus_rw;
                        dev_w_data <= bus_w_data;
                        dev_as_    <= ENABLE_;
                    end
                end
                BUS_SLV_STATE_ACCESS: begin
                    dev_as_ <= DISABLE_;
                    state   <= BUS_SLV_STATE_CAPTURE;
                end
                BUS_SLV_STATE_CAPTURE: begin
                    if (dev_rw == READ) begin
                        rd_buf <= dev_r_data;
                    end
                    dev_w_data <= ZERO;
                    if (WAIT_CYCLES == 0) begin
                        // The buffer loads on this same edge, so forward the device data.
                        state      <= BUS_SLV_STATE_READY;
                        bus_rdy_   <= ENABLE_;
                        bus_r_data <= (dev_rw == READ) ? dev_r_data : ZERO;
                    end else begin
                        wait_cnt <= WAIT_INIT;
                        state    <= BUS_SLV_STATE_WAIT;
                    end
                end
                BUS_SLV_STATE_WAIT: begin
                    if (wait_cnt == '0) begin
                        state      <= BUS_SLV_STATE_READY;
                        bus_rdy_   <= ENABLE_;
                        bus_r_data <= (dev_rw == READ) ? rd_buf : ZERO;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                BUS_SLV_STATE_READY: begin
                    bus_rdy_   <= DISABLE_;
                    bus_r_data <= ZERO;
                    state      <= BUS_SLV_STATE_IDLE;
                end
                default: state <= BUS_SLV_STATE_IDLE;
            endcase
        end
    end

    // The protocol allows one outstanding access; a strobe while busy is dropped.
    busy_strobe_chk: assert property (@(posedge clk) disable iff (!rst)
        (state != BUS_SLV_STATE_IDLE) |-> !(bus_cs_ == ENABLE_ && bus_as_ == ENABLE_))
        else $warning("bus strobe while busy was ignored");

endmodule

// File: tb/tb_yutorina_bus_slave_if.sv
// Directed bench: three slave interfaces (WAIT_CYCLES 0, 2, 15) each with a small
// synchronous RAM model; expected values are hand-computed from the cycle timing.
module tb_yutorina_bus_slave_if;
    import yutorina_bus_slave_if_pkg::*;

    logic             clk;
    logic             rst;
    logic [2:0]       bus_cs_;
    logic             bus_as_;
    logic             bus_rw;
    word_addr_t       bus_addr;
    word_data_t       bus_w_data;
    logic [2:0]       bus_rdy_;
    word_data_t       bus_r_data [3];
    logic [2:0]       dev_as_;
    logic [2:0]       dev_rw;
    logic [11:0]      dev_addr   [3];
    word_data_t       dev_w_data [3];
    word_data_t       dev_r_data [3];
    word_data_t       mem        [3][4096];

    int               n_vec;
    int               n_err;

    int               p_cnt;
    int               p_edge [2];
    word_data_t       p_data [2];
    int               das_cnt;
    logic [11:0]      das_addr0;
    int               stray;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        yutorina_bus_slave_if #(
            .DEV_ADDR_W (12),
            .WAIT_CYCLES((g == 0) ? 0 : (g == 1) ? 2 : 15)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .bus_cs_   (bus_cs_[g]),
            .bus_as_   (bus_as_),
            .bus_rw    (bus_rw),
            .bus_addr  (bus_addr),
            .bus_w_data(bus_w_data),
            .bus_rdy_  (bus_rdy_[g]),
            .bus_r_data(bus_r_data[g]),
            .dev_as_   (dev_as_[g]),
            .dev_rw    (dev_rw[g]),
            .dev_addr  (dev_addr[g]),
            .dev_w_data(dev_w_data[g]),
            .dev_r_data(dev_r_data[g])
        );
    end

    // Synchronous RAM: read data valid the cycle after the strobe.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (dev_as_[k] == ENABLE_) begin
                if (dev_rw[k] == WRITE) mem[k][dev_addr[k]] = dev_w_data[k];
                else dev_r_data[k] <= mem[k][dev_addr[k]];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input int k, input logic rw, input word_addr_t addr, input word_data_t wd);
        bus_cs_    = '1;
        bus_cs_[k] = ENABLE_;
        bus_as_    = ENABLE_;
        bus_rw     = rw;
        bus_addr   = addr;
        bus_w_data = wd;
    endtask

    task automatic idle_bus();
        bus_cs_    = '1;
        bus_as_    = DISABLE_;
        bus_rw     = READ;
        bus_addr   = '0;
        bus_w_data = '0;
    endtask

    // Strobe sampled at edge 0; optional second strobe sampled at edge second_at.
    task automatic run_txn(input int k, input logic rw, input word_addr_t addr,
                           input word_data_t wd, input int second_at, input logic rw2,
                           input word_addr_t addr2, input word_data_t wd2, input int cycles);
        p_cnt = 0; das_cnt = 0; stray = 0; das_addr0 = '0;
        p_edge[0] = -1; p_edge[1] = -1; p_data[0] = '0; p_data[1] = '0;
        @(negedge clk);
        drive(k, rw, addr, wd);
        for (int n = 0; n < cycles; n++) begin
            @(posedge clk);
            #1;
            if (bus_rdy_[k] == ENABLE_) begin
                if (p_cnt < 2) begin
                    p_edge[p_cnt] = n;
                    p_data[p_cnt] = bus_r_data[k];
                end
                p_cnt++;
            end else if (bus_r_data[k] != ZERO) begin
                stray++;
            end
            if (dev_as_[k] == ENABLE_) begin
                if (das_cnt == 0) das_addr0 = dev_addr[k];
                das_cnt++;
            end
            if (n + 1 == second_at) drive(k, rw2, addr2, wd2);
            else idle_bus();
        end
    endtask

    task automatic check_single(input string tag, input int exp_edge, input word_data_t exp_data,
                                input logic [11:0] exp_addr);
        check({tag, "_pulses"}, p_cnt, 1);
        check({tag, "_rdy_edge"}, p_edge[0], exp_edge);
        check({tag, "_rdata"}, p_data[0], exp_data);
        check({tag, "_rdata_idle"}, stray, 0);
        check({tag, "_das_cnt"}, das_cnt, 1);
        check({tag, "_das_addr"}, 32'(das_addr0), 32'(exp_addr));
    endtask

    task automatic check_reset_vals(input int k, input string tag);
        check({tag, "_rdy"}, 32'(bus_rdy_[k]), 32'(DISABLE_));
        check({tag, "_rdata"}, bus_r_data[k], ZERO);
        check({tag, "_das"}, 32'(dev_as_[k]), 32'(DISABLE_));
        check({tag, "_drw"}, 32'(dev_rw[k]), 32'(READ));
        check({tag, "_daddr"}, 32'(dev_addr[k]), 32'd0);
        check({tag, "_dwdata"}, dev_w_data[k], ZERO);
    endtask

    initial begin
        int bad;
        n_vec = 0;
        n_err = 0;
        rst   = 1'b0;
        idle_bus();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4096; i++) mem[k][i] = '0;
            mem[k][12'h010] = 32'hDEAD_BEEF;
            mem[k][12'h001] = 32'h1111_1111;
            mem[k][12'h002] = 32'h2222_2222;
        end

        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) check_reset_vals(k, $sformatf("reset%0d", k));
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Read, no wait states: ready visible 2 edges after the strobe edge.
        run_txn(0, READ, 30'h0000_0010, '0, -1, READ, '0, '0, 8);
        check_single("rd_w0", 2, 32'hDEAD_BEEF, 12'h010);

        // Write with two wait states, then read it back.
        run_txn(1, WRITE, 30'h020, 32'h1234_5678, -1, READ, '0, '0, 10);
        check_single("wr_w2", 4, ZERO, 12'h020);
        check("wr_w2_mem", mem[1][12'h020], 32'h1234_5678);
        run_txn(1, READ, 30'h020, '0, -1, READ, '0, '0, 10);
        check_single("rdback_w2", 4, 32'h1234_5678, 12'h020);

        // Strobe without chip select.
        @(negedge clk);
        bus_as_  = ENABLE_;
        bus_rw   = READ;
        bus_addr = 30'h010;
        bad = 0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk);
            #1;
            idle_bus();
            if (dev_as_ !== 3'b111 || bus_rdy_ !== 3'b111) bad++;
        end
        check("nosel_activity", bad, 0);

        // Second strobe during WAIT must be dropped (would overwrite 0x002 if taken).
        run_txn(1, READ, 30'h010, '0, 3, WRITE, 30'h002, 32'hBAD0_BAD0, 12);
        check_single("spur_w2", 4, 32'hDEAD_BEEF, 12'h010);
        check("spur_w2_mem", mem[1][12'h002], 32'h2222_2222);

        // Reset asserted during CAPTURE.
        @(negedge clk);
        drive(0, READ, 30'h002, '0);
        @(posedge clk); #1; idle_bus();
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check_reset_vals(0, "midrst");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        bad = 0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk);
            #1;
            if (bus_rdy_[0] == ENABLE_ || bus_r_data[0] != ZERO) bad++;
        end
        check("midrst_no_rdy", bad, 0);
        run_txn(0, READ, 30'h010, '0, -1, READ, '0, '0, 8);
        check_single("post_rst_w0", 2, 32'hDEAD_BEEF, 12'h010);

        // Back-to-back with 15 wait states: second strobe in the IDLE cycle after READY.
        run_txn(2, READ, 30'h001, '0, 19, READ, 30'h002, '0, 40);
        check("b2b_pulses", p_cnt, 2);
        check("b2b_edge0", p_edge[0], 17);
        check("b2b_edge1", p_edge[1], 36);
        check("b2b_data0", p_data[0], 32'h1111_1111);
        check("b2b_data1", p_data[1], 32'h2222_2222);
        check("b2b_rdata_idle", stray, 0);
        check("b2b_das_cnt", das_cnt, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
